// File: rtl/uart_tx_arbiter_if.sv
// Client/transmitter-side signal bundle for the shared UART TX arbiter.
// The slave modport is the arbiter's view; master is the clients plus the transmitter.
`timescale 1ns/1ps
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   Req;
  logic [8*NUM_REQ-1:0] Req_Data;
  logic [NUM_REQ-1:0]   Ack;
  logic [ID_W-1:0]      Grant_Id;
  logic                 Busy;
  logic                 TX_En_Sig;
  logic [7:0]           TX_Data;
  logic                 TX_Done_Sig;

  modport master (
    output Req, Req_Data, TX_Done_Sig,
    input  Ack, Grant_Id, Busy, TX_En_Sig, TX_Data
  );

  modport slave (
    input  Req, Req_Data, TX_Done_Sig,
    output Ack, Grant_Id, Busy, TX_En_Sig, TX_Data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte clients.
// One byte per grant; the served client is acked after the transmitter's done pulse.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int GAP_CYC = 2
) (
  input logic              CLK,
  input logic              Rstn,
  uart_tx_arbiter_if.slave arb_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_SEND,
    S_ACK,
    S_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [7:0]         gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;

  logic [7:0]         req_byte [NUM_REQ];
  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      cand_sum;
  logic [ID_W-1:0]    cand;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
      assign req_byte[gi] = arb_if.Req_Data[8*gi +: 8];
    end
  endgenerate

  // First requester at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand = cand_sum[ID_W-1:0];
      if (!win_found && arb_if.Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gap_d   = gap_q;
    ack_d   = '0;
    grant_d = grant_q;
    busy_d  = busy_q;
    en_d    = en_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          data_d  = req_byte[win_idx];
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        en_d    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        // Enable stays high through the done cycle so the transmitter can re-arm.
        if (arb_if.TX_Done_Sig) begin
          en_d    = 1'b0;
          ack_d   = NUM_REQ'(1) << grant_q;
          ptr_d   = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        gap_d = 8'(GAP_CYC);
        if (GAP_CYC == 0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q <= 8'd1) begin
          gap_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Rstn) begin
    if (!Rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gap_q   <= 8'd0;
      ack_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      data_q  <= data_d;
    end
  end

  assign arb_if.Ack       = ack_q;
  assign arb_if.Grant_Id  = grant_q;
  assign arb_if.Busy      = busy_q;
  assign arb_if.TX_En_Sig = en_q;
  assign arb_if.TX_Data   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one GAP_CYC=2 instance and one GAP_CYC=0 instance.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic CLK;
  logic Rstn;
  int   tests = 0;
  int   fails = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus  ();
  uart_tx_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus0 ();

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .GAP_CYC(2)) dut (
    .CLK    (CLK),
    .Rstn   (Rstn),
    .arb_if (bus)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .ID_W(2), .GAP_CYC(0)) dut0 (
    .CLK    (CLK),
    .Rstn   (Rstn),
    .arb_if (bus0)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One complete frame on the GAP_CYC=2 instance, starting from IDLE with Req already set.
  task automatic frame(input int id, input logic [7:0] data, input bit rel, input bit spur);
    step();
    chk("grant_id", 32'(bus.Grant_Id), 32'(id));
    chk("busy_on_grant", 32'(bus.Busy), 32'd1);
    chk("tx_data", 32'(bus.TX_Data), 32'(data));
    chk("en_before_rise", 32'(bus.TX_En_Sig), 32'd0);
    step();
    chk("en_rise", 32'(bus.TX_En_Sig), 32'd1);
    step();
    bus.TX_Done_Sig = 1'b1;
    chk("en_on_done", 32'(bus.TX_En_Sig), 32'd1);
    step();
    bus.TX_Done_Sig = 1'b0;
    chk("en_after_done", 32'(bus.TX_En_Sig), 32'd0);
    chk("ack_pulse", 32'(bus.Ack), 32'(4'b0001 << id));
    if (rel) bus.Req[id] = 1'b0;
    step();
    chk("ack_clear", 32'(bus.Ack), 32'd0);
    chk("busy_gap1", 32'(bus.Busy), 32'd1);
    if (spur) bus.TX_Done_Sig = 1'b1;
    step();
    bus.TX_Done_Sig = 1'b0;
    chk("ack_gap2", 32'(bus.Ack), 32'd0);
    chk("busy_gap2", 32'(bus.Busy), 32'd1);
    step();
    chk("busy_fall", 32'(bus.Busy), 32'd0);
    $display("[TB] frame client %0d data %02h done", id, data);
  endtask

  initial begin
    Rstn = 1'b0;
    bus.Req = '0;  bus.Req_Data = '0;  bus.TX_Done_Sig = 1'b0;
    bus0.Req = '0; bus0.Req_Data = '0; bus0.TX_Done_Sig = 1'b0;
    step();
    step();
    chk("rst_ack", 32'(bus.Ack), 32'd0);
    chk("rst_grant", 32'(bus.Grant_Id), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_en", 32'(bus.TX_En_Sig), 32'd0);
    chk("rst_data", 32'(bus.TX_Data), 32'd0);
    Rstn = 1'b1;

    // Single client 2, with a spurious done pulse during the gap.
    bus.Req = 4'b0100;
    bus.Req_Data = 32'h00A5_0000;
    frame(2, 8'hA5, 1'b1, 1'b1);

    // Spurious done while idle.
    bus.TX_Done_Sig = 1'b1;
    step();
    bus.TX_Done_Sig = 1'b0;
    chk("idle_spur_ack", 32'(bus.Ack), 32'd0);
    chk("idle_spur_busy", 32'(bus.Busy), 32'd0);
    chk("idle_spur_en", 32'(bus.TX_En_Sig), 32'd0);

    // Reset during SEND; pointer is 3 so client 0 wins by wrap.
    bus.Req = 4'b0001;
    bus.Req_Data = 32'h0000_003C;
    step();
    chk("pre_rst_grant", 32'(bus.Grant_Id), 32'd0);
    step();
    chk("pre_rst_en", 32'(bus.TX_En_Sig), 32'd1);
    Rstn = 1'b0;
    #1;
    chk("midrst_en", 32'(bus.TX_En_Sig), 32'd0);
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_ack", 32'(bus.Ack), 32'd0);
    chk("midrst_data", 32'(bus.TX_Data), 32'd0);
    step();
    Rstn = 1'b1;
    $display("[TB] reset during SEND released");
    frame(0, 8'h3C, 1'b1, 1'b0);

    // Reset back to pointer 0, then all four requesting continuously.
    Rstn = 1'b0;
    step();
    Rstn = 1'b1;
    step();
    bus.Req = 4'b1111;
    bus.Req_Data = 32'h1312_1110;
    frame(0, 8'h10, 1'b0, 1'b0);
    frame(1, 8'h11, 1'b0, 1'b0);
    frame(2, 8'h12, 1'b0, 1'b0);
    frame(3, 8'h13, 1'b0, 1'b0);
    frame(0, 8'h10, 1'b0, 1'b0);
    bus.Req = 4'b0000;

    // Client 1 withdraws and changes data mid-SEND; pointer is 1.
    bus.Req = 4'b0010;
    bus.Req_Data = 32'h0000_5A00;
    step();
    chk("drop_grant", 32'(bus.Grant_Id), 32'd1);
    step();
    chk("drop_en", 32'(bus.TX_En_Sig), 32'd1);
    bus.Req = 4'b0000;
    bus.Req_Data = 32'h0000_FF00;
    step();
    chk("drop_data_held", 32'(bus.TX_Data), 32'h5A);
    bus.TX_Done_Sig = 1'b1;
    step();
    bus.TX_Done_Sig = 1'b0;
    chk("drop_ack", 32'(bus.Ack), 32'b0010);
    step();
    step();
    step();
    chk("drop_busy_fall", 32'(bus.Busy), 32'd0);
    step();
    step();
    chk("drop_no_regrant", 32'(bus.Busy), 32'd0);
    chk("drop_no_ack", 32'(bus.Ack), 32'd0);
    $display("[TB] withdraw after grant: frame completed");

    // Pointer at 2 with Req=0011: wrap to client 0, then client 1.
    bus.Req = 4'b0011;
    bus.Req_Data = 32'h0000_2120;
    frame(0, 8'h20, 1'b1, 1'b0);
    frame(1, 8'h21, 1'b1, 1'b0);

    // GAP_CYC=0 instance returns to IDLE straight from ACK.
    bus0.Req = 4'b0001;
    bus0.Req_Data = 32'h0000_0077;
    step();
    chk("g0_grant", 32'(bus0.Grant_Id), 32'd0);
    chk("g0_busy", 32'(bus0.Busy), 32'd1);
    chk("g0_data", 32'(bus0.TX_Data), 32'h77);
    step();
    chk("g0_en", 32'(bus0.TX_En_Sig), 32'd1);
    step();
    bus0.TX_Done_Sig = 1'b1;
    step();
    bus0.TX_Done_Sig = 1'b0;
    bus0.Req = 4'b0000;
    chk("g0_ack", 32'(bus0.Ack), 32'b0001);
    step();
    chk("g0_ack_clear", 32'(bus0.Ack), 32'd0);
    chk("g0_busy_fall", 32'(bus0.Busy), 32'd0);
    $display("[TB] GAP_CYC=0 frame client 0 data 77 done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
